// File: rtl/mcs51_bus_master.sv
// Host-side initiator for the 8051-style multiplexed peripheral bus (cs_n/abus/ale/w_n/r_n/dbus).
// Define MCS51_BUSM_READ_EN to enable read bus cycles; otherwise reads are answered with rsp_err.
module mcs51_bus_master #(
  parameter int unsigned ALE_CYC  = 2,
  parameter int unsigned STB_CYC  = 3,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        cs_n,
  output logic [7:0]  abus,
  output logic        ale,
  output logic        w_n,
  output logic        r_n,
  output logic [7:0]  dbus_o,
  output logic        dbus_oe,
  input  logic [7:0]  dbus_i
);

`ifdef MCS51_BUSM_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_SKIP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [7:0]         wdata_q;
  logic               req_ready_q, rsp_valid_q, rsp_err_q;
  logic [7:0]         rsp_rdata_q;
  logic               cs_n_q, ale_q, w_n_q, r_n_q, dbus_oe_q;
  logic [7:0]         abus_q, dbus_o_q;

  // All outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      ale_q       <= 1'b0;
      w_n_q       <= 1'b1;
      r_n_q       <= 1'b1;
      abus_q      <= '0;
      dbus_o_q    <= '0;
      dbus_oe_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            if (!req_we && !READ_EN) begin
              state_q <= S_SKIP;
            end else begin
              state_q   <= S_ADDR;
              cnt_q     <= CNT_W'(ALE_CYC - 1);
              cs_n_q    <= 1'b0;
              ale_q     <= 1'b1;
              abus_q    <= req_addr[15:8];
              dbus_o_q  <= req_addr[7:0];
              dbus_oe_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (cnt_q == '0) begin
            state_q   <= S_SETUP;
            ale_q     <= 1'b0;
            dbus_o_q  <= we_q ? wdata_q : 8'h00;
            dbus_oe_q <= we_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          cnt_q   <= CNT_W'(STB_CYC - 1);
          w_n_q   <= !we_q;
          r_n_q   <= we_q;
        end
        S_STROBE: begin
          if (cnt_q == '0) begin
            if (!we_q) rsp_rdata_q <= dbus_i;
            state_q <= S_HOLD;
            cnt_q   <= CNT_W'(HOLD_CYC - 1);
            w_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            cs_n_q      <= 1'b1;
            abus_q      <= '0;
            dbus_o_q    <= '0;
            dbus_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        S_SKIP: begin
          // Read path compiled out: answer without touching the bus.
          state_q     <= S_DONE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs_n      = cs_n_q;
  assign ale       = ale_q;
  assign w_n       = w_n_q;
  assign r_n       = r_n_q;
  assign abus      = abus_q;
  assign dbus_o    = dbus_o_q;
  assign dbus_oe   = dbus_oe_q;

endmodule
